// File: rtl/fg_bbox_tracker.sv
// fg_bbox_tracker: bounding box, pixel count and empty flag of the
// foreground pixels in a raster-ordered mask stream.
// A report pulse comes one cycle after the last pixel of each frame. A stray
// start-of-frame in mid-frame pulses a drop and restarts the frame.
// Optional feature macro: FG_RUN_FILTER_EN. When defined, a pixel is counted
// only if it and the previously accepted pixel on the same line are both
// foreground, so pixels at x=0 never count.
module fg_bbox_tracker #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic        i_fg,
  output logic        o_bbox_valid,
  output logic [9:0]  o_xmin,
  output logic [9:0]  o_xmax,
  output logic [8:0]  o_ymin,
  output logic [8:0]  o_ymax,
  output logic [18:0] o_count,
  output logic        o_empty,
  output logic        o_drop
);

  localparam logic [9:0] X_LAST = 10'(FRAME_W - 1);
  localparam logic [8:0] Y_LAST = 9'(FRAME_H - 1);

  typedef enum logic [1:0] {SYNC, ACCUM, REPORT} state_t;

  state_t state, state_next;

  logic [9:0]  x, xmin, xmax;
  logic [8:0]  y, ymin, ymax;
  logic [18:0] count;

  logic        accept, at_origin, drop, first, last, counted;
  logic [9:0]  px, x_next, base_xmin, base_xmax, new_xmin, new_xmax;
  logic [8:0]  py, y_next, base_ymin, base_ymax, new_ymin, new_ymax;
  logic [18:0] base_count, new_count;

`ifdef FG_RUN_FILTER_EN
  logic prev_fg;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_next;
  end

  // Next state, pixel acceptance and position of the accepted pixel
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    at_origin  = 1'b0;
    drop       = 1'b0;
    case (state)
      SYNC: begin
        if (i_valid && i_sof) begin
          accept     = 1'b1;
          at_origin  = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          accept = 1'b1;
          if (i_sof && (x != '0 || y != '0)) begin
            drop      = 1'b1;
            at_origin = 1'b1;
          end
        end
      end
      REPORT: begin
        state_next = ACCUM;
        if (i_valid) begin
          accept    = 1'b1;
          at_origin = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
    px    = at_origin ? '0 : x;
    py    = at_origin ? '0 : y;
    first = (px == '0) && (py == '0);
    last  = accept && (px == X_LAST) && (py == Y_LAST);
    if (last) state_next = REPORT;
  end

  // Running extents: the pixel at (0,0) restarts from the initial values
  // rather than relying on a separate clear step, which covers frame start
  // from SYNC, from REPORT and from a mid-frame restart alike.
  always_comb begin
    base_xmin  = first ? '1 : xmin;
    base_xmax  = first ? '0 : xmax;
    base_ymin  = first ? '1 : ymin;
    base_ymax  = first ? '0 : ymax;
    base_count = first ? '0 : count;
`ifdef FG_RUN_FILTER_EN
    counted    = accept && i_fg && prev_fg && (px != '0);
`else
    counted    = accept && i_fg;
`endif
    new_xmin   = (counted && px < base_xmin) ? px : base_xmin;
    new_xmax   = (counted && px > base_xmax) ? px : base_xmax;
    new_ymin   = (counted && py < base_ymin) ? py : base_ymin;
    new_ymax   = (counted && py > base_ymax) ? py : base_ymax;
    new_count  = base_count + {18'd0, counted};
    x_next     = (px == X_LAST) ? '0 : px + 10'd1;
    if (px == X_LAST) y_next = (py == Y_LAST) ? '0 : py + 9'd1;
    else              y_next = py;
  end

  // Raster counters, accumulators and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      xmin         <= '0;
      xmax         <= '0;
      ymin         <= '0;
      ymax         <= '0;
      count        <= '0;
      o_bbox_valid <= 1'b0;
      o_drop       <= 1'b0;
      o_xmin       <= '0;
      o_xmax       <= '0;
      o_ymin       <= '0;
      o_ymax       <= '0;
      o_count      <= '0;
      o_empty      <= 1'b0;
    end else begin
      o_bbox_valid <= last;
      o_drop       <= drop;
      if (accept) begin
        x     <= x_next;
        y     <= y_next;
        xmin  <= new_xmin;
        xmax  <= new_xmax;
        ymin  <= new_ymin;
        ymax  <= new_ymax;
        count <= new_count;
      end
      if (last) begin
        o_empty <= (new_count == '0);
        o_count <= new_count;
        o_xmin  <= (new_count == '0) ? '0 : new_xmin;
        o_xmax  <= (new_count == '0) ? '0 : new_xmax;
        o_ymin  <= (new_count == '0) ? '0 : new_ymin;
        o_ymax  <= (new_count == '0) ? '0 : new_ymax;
      end
    end
  end

`ifdef FG_RUN_FILTER_EN
  // Foreground flag of the previously accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prev_fg <= 1'b0;
    else if (accept) prev_fg <= i_fg;
  end
`endif

endmodule

// File: tb/tb_fg_bbox_tracker.sv
// Testbench for fg_bbox_tracker on a reduced frame size, randomized stimulus
// checked cycle by cycle against a pixel-list reference model.
// Honours FG_RUN_FILTER_EN in the model when the macro is defined.
module tb_fg_bbox_tracker;

  localparam int W = 24;
  localparam int H = 10;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic        i_fg = 1'b0;
  logic        o_bbox_valid, o_empty, o_drop;
  logic [9:0]  o_xmin, o_xmax;
  logic [8:0]  o_ymin, o_ymax;
  logic [18:0] o_count;

  fg_bbox_tracker #(.FRAME_W(W), .FRAME_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_fg(i_fg),
    .o_bbox_valid(o_bbox_valid), .o_xmin(o_xmin), .o_xmax(o_xmax),
    .o_ymin(o_ymin), .o_ymax(o_ymax), .o_count(o_count),
    .o_empty(o_empty), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle_no = 0;

  // Reference model: linear pixel index within the frame and the list of
  // counted pixel coordinates; the box is derived from the list at frame end.
  bit          synced = 1'b0;
  int          pos = 0;
  int          qx[$];
  int          qy[$];
  logic        exp_valid = 1'b0;
  logic        exp_drop = 1'b0;
  logic [57:0] exp_box = '0;
`ifdef FG_RUN_FILTER_EN
  logic        prev_fg = 1'b0;
`endif

  bit gap_chk = 1'b0;
  int last_pulse = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle_no);
    end
  endtask

  task automatic model_reset();
    synced    = 1'b0;
    pos       = 0;
    qx.delete();
    qy.delete();
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    exp_box   = '0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic f);
    int   px, py, xmn, xmx, ymn, ymx;
    logic cnt;
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    if (!v) return;
    if (!synced) begin
      if (!s) return;
      synced = 1'b1;
      pos = 0;
      qx.delete();
      qy.delete();
    end else if (s && pos != 0) begin
      exp_drop = 1'b1;
      pos = 0;
      qx.delete();
      qy.delete();
    end
    px  = pos % W;
    py  = pos / W;
    cnt = f;
`ifdef FG_RUN_FILTER_EN
    cnt = f && prev_fg && (px != 0);
    prev_fg = f;
`endif
    if (cnt) begin
      qx.push_back(px);
      qy.push_back(py);
    end
    pos++;
    if (pos == N) begin
      exp_valid = 1'b1;
      if (qx.size() == 0) begin
        exp_box = {10'd0, 10'd0, 9'd0, 9'd0, 19'd0, 1'b1};
      end else begin
        xmn = W; xmx = -1; ymn = H; ymx = -1;
        foreach (qx[i]) begin
          if (qx[i] < xmn) xmn = qx[i];
          if (qx[i] > xmx) xmx = qx[i];
          if (qy[i] < ymn) ymn = qy[i];
          if (qy[i] > ymx) ymx = qy[i];
        end
        exp_box = {10'(xmn), 10'(xmx), 9'(ymn), 9'(ymx), 19'(qx.size()), 1'b0};
      end
      pos = 0;
      qx.delete();
      qy.delete();
    end
  endtask

  // One clock: drive inputs, advance the model, sample at the falling edge.
  task automatic cyc(input logic v, input logic s, input logic f);
    i_valid = v;
    i_sof   = s;
    i_fg    = f;
    if (rst_n) model_step(v, s, f);
    else begin
      exp_valid = 1'b0;
      exp_drop  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cycle_no++;
    check("bbox_valid", 64'(o_bbox_valid), 64'(exp_valid));
    check("drop", 64'(o_drop), 64'(exp_drop));
    check("box", 64'({o_xmin, o_xmax, o_ymin, o_ymax, o_count, o_empty}), 64'(exp_box));
    if (gap_chk && o_bbox_valid === 1'b1) begin
      if (last_pulse >= 0) check("pulse_gap", 64'(cycle_no - last_pulse), 64'(N));
      last_pulse = cycle_no;
    end
  endtask

  function automatic logic fg_at(input int mode, input int x, input int y);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ($urandom_range(3, 0) == 0);
      3: return (x == 5 && y == 2) || (x == 6 && y == 2) || (x == 17 && y == 8);
      default: return ($urandom_range(3, 0) != 0);
    endcase
  endfunction

  // Sends npix pixels starting at frame pixel 0; gap idle cycles before each
  // (random 0..gap when rgap is set), optional sof on the first pixel and a
  // small chance of a stray sof when stray is set.
  task automatic send_frame(input int mode, input int gap, input bit rgap,
                            input bit sof_first, input bit stray, input int npix);
    int  g;
    bit  s;
    for (int p = 0; p < npix; p++) begin
      g = rgap ? int'($urandom_range(gap, 0)) : gap;
      for (int k = 0; k < g; k++) cyc(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      s = (sof_first && p == 0) || (stray && $urandom_range(149, 0) == 0);
      cyc(1'b1, s, fg_at(mode, p % W, p / W));
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;

    // Pixels before the first sof are ignored
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b1);

    // Sparse directed mask, valid every 4th cycle
    send_frame(3, 3, 1'b0, 1'b1, 1'b0, N);
    // All-zero mask
    send_frame(0, 1, 1'b1, 1'b1, 1'b0, N);
    // Restart at (20,3), then a full frame
    send_frame(4, 1, 1'b1, 1'b1, 1'b0, 3 * W + 20);
    send_frame(2, 1, 1'b1, 1'b1, 1'b0, N);

    // Asynchronous reset at pixel (0,5)
    send_frame(4, 0, 1'b0, 1'b1, 1'b0, 5 * W);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 64'(o_bbox_valid), 64'd0);
    check("async_rst_box", 64'({o_xmin, o_xmax, o_ymin, o_ymax, o_count, o_empty}), 64'd0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'($urandom_range(1, 0)), 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b1);
    send_frame(4, 2, 1'b1, 1'b1, 1'b0, N);

    // Random frames, random duty, occasional omitted or stray sof
    for (int f = 0; f < 12; f++)
      send_frame(($urandom_range(1, 0) != 0) ? 2 : 4, 3, 1'b1,
                 1'($urandom_range(1, 0)), 1'b1, N);

    // Back-to-back all-ones frames with continuous valid
    gap_chk = 1'b1;
    last_pulse = -1;
    send_frame(1, 0, 1'b0, 1'b1, 1'b0, N);
    send_frame(1, 0, 1'b0, 1'b0, 1'b0, N);
    send_frame(1, 0, 1'b0, 1'b0, 1'b0, N);
    cyc(1'b0, 1'b0, 1'b0);
    gap_chk = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fg_bbox_tracker.md
FG_BBOX_TRACKER -- requirements
Module: fg_bbox_tracker

Interface
REQ-001 Parameter FRAME_W, default 640, active pixels per line.
REQ-002 Parameter FRAME_H, default 480, active lines per frame.
REQ-003 clk  input  1  pixel-pipeline clock, 100 MHz domain shared with the background-subtraction stage.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  one foreground-mask pixel is presented this cycle (raster order, sparse, any duty cycle).
REQ-006 i_sof  input  1  start-of-frame; qualified by i_valid, marks pixel (0,0).
REQ-007 i_fg  input  1  foreground flag from the background-subtraction stage, qualified by i_valid.
REQ-008 o_bbox_valid  output  1  one-cycle pulse: box outputs hold a completed frame's result.
REQ-009 o_xmin, o_xmax  output  10 each  horizontal extent of counted foreground pixels.
REQ-010 o_ymin, o_ymax  output  9 each  vertical extent of counted foreground pixels.
REQ-011 o_count  output  19  number of counted foreground pixels in the frame.
REQ-012 o_empty  output  1  frame contained zero counted pixels.
REQ-013 o_drop  output  1  one-cycle pulse: partial frame discarded.

Function
REQ-014 Internal raster counters x (0..FRAME_W-1) and y (0..FRAME_H-1) advance only on accepted pixels (i_valid=1); x wraps to 0 and increments y at FRAME_W-1.
REQ-015 States: SYNC (discard pixels until i_valid&i_sof), ACCUM (accumulate), REPORT (one cycle, drive result).
REQ-016 SYNC->ACCUM on i_valid&i_sof; that pixel is treated as (0,0) and is itself accumulated.
REQ-017 In ACCUM, a counted pixel updates running min/max of x and y, and increments the count by 1.
REQ-018 Running mins initialise to all-ones and maxes to 0 at each frame start.
REQ-019 Accepting pixel (FRAME_W-1, FRAME_H-1) moves ACCUM->REPORT; the next cycle o_bbox_valid=1 with registered results (latency 1 cycle after the last pixel).
REQ-020 REPORT->ACCUM unconditionally after one cycle; the counters are reset to (0,0) and the next frame is expected without a new i_sof requirement.
REQ-021 Outputs o_xmin..o_count and o_empty hold their last reported values until the next report.
REQ-022 Empty frame: o_bbox_valid still pulses, o_empty=1, all coordinates and o_count = 0.
REQ-023 i_valid&i_sof while in ACCUM with (x,y) != (0,0): pulse o_drop for one cycle, discard the partial accumulation, restart the frame with this pixel as (0,0); no report is issued.
REQ-024 i_valid&i_sof while in REPORT: report still issued, and the pixel starts the next frame as (0,0).
REQ-025 i_valid during REPORT with i_sof=0 is accepted as pixel (0,0) of the next frame.
REQ-026 o_count is 19 bits and cannot overflow at FRAME_W*FRAME_H <= 524287; no saturation logic.

Reset
REQ-027 rst_n low asynchronously forces SYNC, counters to 0, all outputs to 0 (o_bbox_valid=0, o_drop=0, o_empty=0).
REQ-028 Reset asserted mid-frame discards the accumulation; no report or o_drop is produced for that frame.
REQ-029 After release, no pixel is accumulated before the first i_valid&i_sof.

Configuration
REQ-030 Macro FG_RUN_FILTER_EN defined: a pixel is counted only if i_fg=1 for it and for the previously accepted pixel on the same line; pixels at x=0 are never counted.
REQ-031 FG_RUN_FILTER_EN undefined: every accepted pixel with i_fg=1 is counted; no run-history register is instantiated.

Verification
REQ-032 Full 640x480 frame, i_valid every 4th cycle, i_fg=1 only at (100,50) and (300,200) -> one pulse: xmin=100, xmax=300, ymin=50, ymax=200, count=2 (filter off).
REQ-033 Same frame with FG_RUN_FILTER_EN and fg at (10,5),(11,5),(400,7) -> xmin=xmax=11, ymin=ymax=5, count=1.
REQ-034 All-zero mask frame -> o_bbox_valid pulse, o_empty=1, all coordinates and count = 0.
REQ-035 i_sof re-asserted at pixel (20,3) mid-frame -> o_drop pulse; the next full frame reports only pixels after the restart.
REQ-036 rst_n pulsed low at pixel (0,240), then frames resume with i_sof -> no report for the aborted frame; the next frame reports correctly.
REQ-037 Frame of all-ones mask, back-to-back frames with i_valid continuous -> count=307200, box (0,0)-(639,479) on each pulse, with pulses exactly 307200 cycles apart.
